// File: rtl/uart_rx_checker.sv
// Self-checking sink for a UART receiver: expected words are queued in a
// small FIFO, each received word is compared against the queue head, and
// the run ends either when the requested number of words has arrived or
// when the timer expires.
module uart_rx_checker #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 150000,
    parameter int TIMEOUT_MODE   = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  expect_count,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  first_bad_index,
    output logic [DATA_WIDTH-1:0] last_rx
);

    // The timer only ever needs to hold 0..TIMEOUT_CYCLES-1, so it is sized
    // from the limit rather than from CNT_WIDTH; the default limit would not
    // fit in a 16-bit counter.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]          FIFO_FULL  = (AW + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fill;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  push;
    logic                  accept;
    logic                  start_ok;
    logic                  word_bad;
    logic                  completes;
    logic                  expires;
    logic [CNT_WIDTH-1:0]  word_count_inc;
    logic [CNT_WIDTH-1:0]  mismatch_inc;
    logic [CNT_WIDTH-1:0]  mismatch_after;
    logic [CNT_WIDTH-1:0]  expect_q;
    logic [TW-1:0]         timer;

    // A full FIFO refuses new words even when a pop happens in the same cycle.
    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_empty = (fill == '0);
    assign exp_ready  = (fill < FIFO_FULL);
    assign push       = exp_valid && exp_ready;
    assign accept     = rx_valid && rx_ready;
    assign start_ok   = start && (state != RUN);
    assign word_bad   = (rx_data != fifo_head);

    // Counters stick at all-ones instead of wrapping.
    assign word_count_inc = (word_count == CNT_MAX) ? word_count : word_count + CNT_WIDTH'(1);
    assign mismatch_inc   = (mismatch_count == CNT_MAX) ? mismatch_count : mismatch_count + CNT_WIDTH'(1);
    assign mismatch_after = (accept && word_bad) ? mismatch_inc : mismatch_count;
    assign completes      = accept && (word_count_inc == expect_q);
    assign expires        = (timer == TIMER_LAST);

    // Expected-word storage; contents need no reset since fill tracks validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= exp_data;
        end
    end

    // FIFO pointers and occupancy; start deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, accept})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a zero-length check finishes immediately; completion beats expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (expect_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (completes || expires) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy     = (state == RUN);
        done     = (state == DONE);
        rx_ready = (state == RUN) && !fifo_empty;
    end

    // Run bookkeeping: counters, timer, result flags and the latched target.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count      <= '0;
            mismatch_count  <= '0;
            first_bad_index <= CNT_MAX;
            last_rx         <= '0;
            timer           <= '0;
            expect_q        <= '0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
        end else if (start_ok) begin
            word_count      <= '0;
            mismatch_count  <= '0;
            first_bad_index <= CNT_MAX;
            timer           <= '0;
            expect_q        <= expect_count;
            pass            <= (expect_count == '0);
            timeout         <= 1'b0;
        end else if (state == RUN) begin
            if (TIMEOUT_MODE == 1 && accept) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if (accept) begin
                word_count     <= word_count_inc;
                last_rx        <= rx_data;
                mismatch_count <= mismatch_after;
                if (word_bad && first_bad_index == CNT_MAX) begin
                    first_bad_index <= word_count;
                end
            end
            if (completes) begin
                pass    <= (mismatch_after == '0);
                timeout <= 1'b0;
            end else if (expires) begin
                pass    <= 1'b0;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_checker.md
UART_RX_CHECKER -- requirements
Module: uart_rx_checker

Interface
- REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  - DATA_WIDTH, 8, width of received and expected words.
  - DEPTH, 16, expected-word FIFO entries (power of 2, >=2).
  - TIMEOUT_CYCLES, 150000, timeout limit in clk cycles (>=1).
  - TIMEOUT_MODE, 0, 0 = global (counted from start), 1 = per-word (counter restarts on each accepted word).
  - CNT_WIDTH, 16, width of all counters.
- REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  - clk, input, 1, single clock; all logic on rising edge.
  - rst, input, 1, synchronous active-high reset.
  - exp_data, input, DATA_WIDTH, expected word to enqueue.
  - exp_valid, input, 1, exp_data valid.
  - exp_ready, output, 1, FIFO not full.
  - start, input, 1, one-cycle pulse that arms checking.
  - expect_count, input, CNT_WIDTH, number of words to check; sampled at start.
  - rx_data, input, DATA_WIDTH, word from receiver (UART data_out).
  - rx_valid, input, 1, receiver word valid.
  - rx_ready, output, 1, consume receiver word.
  - busy, output, 1, checker in RUN.
  - done, output, 1, check finished; held until next start.
  - pass, output, 1, done with zero mismatches and no timeout.
  - timeout, output, 1, finished by timeout.
  - mismatch_count, output, CNT_WIDTH, mismatching words so far.
  - word_count, output, CNT_WIDTH, words accepted so far.
  - first_bad_index, output, CNT_WIDTH, index of first mismatch; all-ones if none.
  - last_rx, output, DATA_WIDTH, last accepted word.

Function
- REQ-003 States SHALL be IDLE, RUN, DONE.
- REQ-004 Expected FIFO SHALL enqueue on exp_valid && exp_ready in any state.
- REQ-005 exp_ready SHALL be 1 iff FIFO occupancy < DEPTH.
- REQ-006 A simultaneous enqueue and dequeue on a full FIFO SHALL be refused; exp_ready=0 governs.
- REQ-007 IDLE/DONE + start SHALL go to RUN next cycle.
- REQ-008 On that transition, counters SHALL clear, the timer SHALL clear, done/pass/timeout SHALL clear, and expect_count SHALL latch.
- REQ-009 start with expect_count==0 SHALL go directly to DONE with pass=1.
- REQ-010 start while in RUN SHALL be ignored.
- REQ-011 rx_ready SHALL be combinational: 1 iff state==RUN and FIFO non-empty.
- REQ-012 A word SHALL be accepted on rx_valid && rx_ready. On accept:
  - FIFO head pops.
  - rx_data is compared to the head with full-width equality.
  - word_count increments.
  - last_rx is updated.
  - On inequality, mismatch_count increments; first_bad_index takes the pre-increment word_count if it is still all-ones.
- REQ-013 At most one word SHALL be accepted per cycle.
- REQ-014 When an accept makes word_count equal the latched count, the next state SHALL be DONE with done=1 and pass=(mismatch_count after update == 0).
- REQ-015 The timer SHALL increment every RUN cycle. In TIMEOUT_MODE 1 it SHALL reset to 0 on each accept.
- REQ-016 When the timer reaches TIMEOUT_CYCLES-1 without a completing accept, the next state SHALL be DONE with done=1, timeout=1, pass=0.
- REQ-017 If the completing accept and timer expiry coincide, completion SHALL win (timeout=0).
- REQ-018 Counters SHALL saturate at all-ones, never wrap.
- REQ-019 The FIFO SHALL not be flushed by start; leftover entries persist.
- REQ-020 busy SHALL equal (state==RUN).
- REQ-021 All registered outputs SHALL update on clk rising edge only.

Reset
- REQ-022 rst SHALL take precedence over all inputs, including mid-RUN.
- REQ-023 After rst, state SHALL be IDLE and FIFO SHALL be empty.
- REQ-024 Reset output values SHALL be:
  - exp_ready=1, rx_ready=0, busy=0.
  - done=0, pass=0, timeout=0.
  - mismatch_count=0, word_count=0.
  - first_bad_index=all-ones, last_rx=0.
- REQ-025 Timer and latched count SHALL reset to 0.

Verification
- REQ-026 Basic pass:
  - Stimulus: enqueue 0x64, 0xF4; start with count=2; drive both words.
  - Required: done=1, pass=1, word_count=2, last_rx=0xF4.
- REQ-027 Mismatch:
  - Stimulus: expect 0x01,0x02,0x03; receive 0x01,0x07,0x09.
  - Required: mismatch_count=2, first_bad_index=1, pass=0.
- REQ-028 Global timeout:
  - Stimulus: TIMEOUT_CYCLES=100, mode 0; count=2; one word at cycle 10.
  - Required: timeout=1 exactly 100 cycles after entering RUN, word_count=1.
- REQ-029 Per-word timer:
  - Stimulus: mode 1, TIMEOUT_CYCLES=100; words every 80 cycles, count=5.
  - Required: pass=1, no timeout.
- REQ-030 FIFO full:
  - Stimulus: DEPTH=4; push 5 words back-to-back.
  - Required: exp_ready=0 after 4th; 5th held until a pop.
- REQ-031 Reset mid-RUN:
  - Stimulus: assert rst after 1 accepted word.
  - Required: all REQ-024 values next cycle, FIFO empty, rx_ready=0.
